// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM input,
// derives the integer duty cycle with a restoring divider and flags stuck inputs.
module pwm_capture #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [6:0]       duty_pct,
    output logic             valid,
    output logic             stuck_high,
    output logic             stuck_low
);

    localparam int               NUM_W     = CNT_W + 7;
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [2:0]       LAST_STEP = 3'd6;

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } state_t;

    logic             s1_r;
    logic             s2_r;
    logic             prev_r;
    logic             rise_s;
    logic             fall_s;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [CNT_W-1:0] hi_lat_r;
    logic [CNT_W-1:0] cap_per_r;
    logic [CNT_W-1:0] cap_hi_r;
    logic             start_s;
    logic             sh_set_s;
    logic             sl_set_s;

    logic             busy_r;
    logic [2:0]       step_r;
    logic [NUM_W-1:0] rem_r;
    logic [NUM_W-1:0] den_r;
    logic [NUM_W-1:0] rem_nxt_s;
    logic [NUM_W-1:0] hi_ext_s;
    logic [NUM_W-1:0] num_s;
    logic [6:0]       quo_r;
    logic [6:0]       quo_nxt_s;
    logic             ge_s;
    logic             done_s;

    // Two-flop synchronizer plus one delay stage for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_r   <= 1'b0;
            s2_r   <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            s1_r   <= pwm_in;
            s2_r   <= s1_r;
            prev_r <= s2_r;
        end
    end

    // Edge decode and saturating counter increment
    always_comb begin
        rise_s    = s2_r & ~prev_r;
        fall_s    = ~s2_r & prev_r;
        cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
    end

    // Divider start and stuck-flag set requests decoded from the FSM state
    always_comb begin
        start_s  = 1'b0;
        sh_set_s = 1'b0;
        sl_set_s = 1'b0;
        case (state_r)
            MEAS_HIGH: begin
                if (!fall_s && (cnt_r == TIMEOUT_C)) begin
                    sh_set_s = 1'b1;
                end else begin
                    sh_set_s = 1'b0;
                end
            end
            MEAS_LOW: begin
                if (rise_s) begin
                    start_s = 1'b1;
                end else if (cnt_r == TIMEOUT_C) begin
                    sl_set_s = 1'b1;
                end else begin
                    start_s  = 1'b0;
                    sl_set_s = 1'b0;
                end
            end
            default: begin
                start_s  = 1'b0;
                sh_set_s = 1'b0;
                sl_set_s = 1'b0;
            end
        endcase
    end

    // Measurement FSM: cycle counting between edges
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= WAIT_RISE;
            cnt_r     <= {CNT_W{1'b0}};
            hi_lat_r  <= {CNT_W{1'b0}};
            cap_per_r <= {CNT_W{1'b0}};
            cap_hi_r  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                WAIT_RISE: begin
                    if (rise_s) begin
                        cnt_r   <= CNT_ONE;
                        state_r <= MEAS_HIGH;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                MEAS_HIGH: begin
                    cnt_r <= cnt_inc_s;
                    if (fall_s) begin
                        hi_lat_r <= cnt_r;
                        state_r  <= MEAS_LOW;
                    end else if (cnt_r == TIMEOUT_C) begin
                        state_r <= WAIT_RISE;
                    end
                end
                MEAS_LOW: begin
                    if (rise_s) begin
                        cap_per_r <= cnt_r;
                        cap_hi_r  <= hi_lat_r;
                        cnt_r     <= CNT_ONE;
                        state_r   <= MEAS_HIGH;
                    end else begin
                        cnt_r <= cnt_inc_s;
                        if (cnt_r == TIMEOUT_C) begin
                            state_r <= WAIT_RISE;
                        end
                    end
                end
                default: begin
                    state_r <= WAIT_RISE;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Divider datapath: numerator hi*100 built from shifts, one quotient bit per step
    always_comb begin
        hi_ext_s  = {7'd0, hi_lat_r};
        num_s     = (hi_ext_s << 3'd6) + (hi_ext_s << 3'd5) + (hi_ext_s << 3'd2);
        ge_s      = (rem_r >= den_r);
        rem_nxt_s = ge_s ? (rem_r - den_r) : rem_r;
        quo_nxt_s = {quo_r[5:0], ge_s};
        done_s    = busy_r & ~start_s & (step_r == LAST_STEP);
    end

    // Restoring divider; a new start always restarts and drops any result in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
            step_r <= 3'd0;
            rem_r  <= {NUM_W{1'b0}};
            den_r  <= {NUM_W{1'b0}};
            quo_r  <= 7'd0;
        end else if (start_s) begin
            busy_r <= 1'b1;
            step_r <= 3'd0;
            rem_r  <= num_s;
            den_r  <= {1'b0, cnt_r, 6'd0};
            quo_r  <= 7'd0;
        end else if (busy_r) begin
            rem_r  <= rem_nxt_s;
            den_r  <= {1'b0, den_r[NUM_W-1:1]};
            quo_r  <= quo_nxt_s;
            step_r <= step_r + 3'd1;
            busy_r <= (step_r != LAST_STEP);
        end
    end

    // Registered outputs; a stuck condition raised on the completion edge wins over the clear
    always_ff @(posedge clk) begin
        if (reset) begin
            period     <= {CNT_W{1'b0}};
            high_time  <= {CNT_W{1'b0}};
            duty_pct   <= 7'd0;
            valid      <= 1'b0;
            stuck_high <= 1'b0;
            stuck_low  <= 1'b0;
        end else begin
            valid <= done_s;
            if (done_s) begin
                period    <= cap_per_r;
                high_time <= cap_hi_r;
                duty_pct  <= quo_nxt_s;
            end
            if (sh_set_s) begin
                stuck_high <= 1'b1;
            end else if (done_s) begin
                stuck_high <= 1'b0;
            end
            if (sl_set_s) begin
                stuck_low <= 1'b1;
            end else if (done_s) begin
                stuck_low <= 1'b0;
            end
        end
    end

endmodule
